mem_port_arbiter: RTL

Shares the single SRAM-style memory port between the instruction-fetch and data-access requesters of the myCPU pipeline. The block sits between the fetch/memory stages and the bus interface. It grants one requester at a time and allows one outstanding transaction. It forwards the request fields and routes the returned handshake and read data back to the requester that owns the transaction.

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-style memory port between instruction fetch
// and data access, one outstanding transaction at a time. Ties alternate with
// the data side winning the first one; responses route back to the owner.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int unsigned SIZE_W = 2;
    localparam logic [SIZE_W-1:0] SIZE_WORD = SIZE_W'(2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    typedef enum logic {
        REQ_INST = 1'b0,
        REQ_DATA = 1'b1
    } req_e;

    state_e              state_q, state_d;
    req_e                owner_q, owner_d;
    req_e                last_q,  last_d;
    logic                bus_req_q, bus_req_d;
    logic                wr_q, wr_d;
    logic [SIZE_W-1:0]   size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                grant_inst, grant_data;
    logic                resp_inst, resp_data;

    // State, ownership and latched bus fields; reset abandons any transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= REQ_INST;
            last_q    <= REQ_INST;
            bus_req_q <= 1'b0;
            wr_q      <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            bus_req_q <= bus_req_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    // Grant selection, field latching and transaction sequencing.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        bus_req_d  = bus_req_q;
        wr_d       = wr_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        resp_inst  = 1'b0;
        resp_data  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Data wins when alone or when the last grant went to fetch.
                if (data_req && (!inst_req || last_q == REQ_INST)) begin
                    grant_data = 1'b1;
                    wr_d       = data_wr;
                    size_d     = data_size;
                    addr_d     = data_addr;
                    wdata_d    = data_wdata;
                    owner_d    = REQ_DATA;
                    last_d     = REQ_DATA;
                    bus_req_d  = 1'b1;
                    state_d    = ST_ADDR;
                end else if (inst_req) begin
                    grant_inst = 1'b1;
                    wr_d       = 1'b0;
                    size_d     = SIZE_WORD;
                    addr_d     = inst_addr;
                    wdata_d    = '0;
                    owner_d    = REQ_INST;
                    last_d     = REQ_INST;
                    bus_req_d  = 1'b1;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus_addr_ok) begin
                    bus_req_d = 1'b0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                bus_req_d = 1'b0;
                if (bus_data_ok) begin
                    resp_inst = (owner_q == REQ_INST);
                    resp_data = (owner_q == REQ_DATA);
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                bus_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Handshakes are combinational and held low while reset is asserted.
    always_comb begin
        inst_addr_ok = rst & grant_inst;
        data_addr_ok = rst & grant_data;
        inst_data_ok = rst & resp_inst;
        data_data_ok = rst & resp_data;
    end

    assign inst_rdata = bus_rdata;
    assign data_rdata = bus_rdata;

    assign bus_req   = bus_req_q;
    assign bus_wr    = wr_q;
    assign bus_size  = size_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

endmodule
